// File: rtl/condiciona_pkg.sv
// Shared types and defaults for the button conditioner.
// Holds the FSM state codes and the default debounce length.
package condiciona_pkg;

  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    PRESSIONADO = 2'd1,
    MULTIPLO    = 2'd2
  } estado_t;

  function automatic logic um_so(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/condiciona_botoes_if.sv
// One-bit link between the top and a debounce_bit slice.
// raw: pin level into the slice; estavel: debounced level out.
interface condiciona_botoes_if;
  logic raw;
  logic estavel;

  modport master (
    output raw,
    input  estavel
  );

  modport slave (
    input  raw,
    output estavel
  );
endinterface

// File: rtl/debounce_bit.sv
// Single-bit debouncer: optional 2-flop synchronizer, counter, stable flop.
// Ports: clock, reset (sync, active-high), bus (slave: raw in, estavel out).
// Macro CONDICIONA_SINCRONIZADOR_EN inserts the 2-flop synchronizer.
module debounce_bit
  import condiciona_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input logic                clock,
  input logic                reset,
  condiciona_botoes_if.slave bus
);

  localparam int CW = (DEBOUNCE_CICLOS > 2) ?
                      $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

  logic amostra;

`ifdef CONDICIONA_SINCRONIZADOR_EN
  logic [1:0] sinc_q, sinc_d;

  always_comb begin
    sinc_d = {sinc_q[0], bus.raw};
  end

  always_ff @(posedge clock) begin
    if (reset) sinc_q <= 2'b00;
    else       sinc_q <= sinc_d;
  end

  assign amostra = sinc_q[1];
`else
  assign amostra = bus.raw;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic          estavel_q, estavel_d;

  // Counter only runs while the sample disagrees with the
  // accepted level; it tops out at LIMITE where the flip happens.
  always_comb begin
    cnt_d     = '0;
    estavel_d = estavel_q;
    if (amostra != estavel_q) begin
      if (cnt_q == LIMITE) estavel_d = ~estavel_q;
      else                 cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      estavel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      estavel_q <= estavel_d;
    end
  end

  assign bus.estavel = estavel_q;

endmodule

// File: rtl/condiciona_botoes.sv
// Debounces 4 buttons and classifies presses as single or multiple.
// Ports: clock, reset, botoes_raw in; botoes, jogada_feita, jogada_codigo,
// multiplo, db_estado out. Macro CONDICIONA_SINCRONIZADOR_EN adds sync.
module condiciona_botoes
  import condiciona_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_raw,
  output logic [3:0] botoes,
  output logic       jogada_feita,
  output logic [3:0] jogada_codigo,
  output logic       multiplo,
  output logic [3:0] db_estado
);

  logic [3:0] estaveis;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    condiciona_botoes_if bif ();
    assign bif.raw     = botoes_raw[i];
    assign estaveis[i] = bif.estavel;
    debounce_bit #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .bus  (bif)
    );
  end

  assign botoes = estaveis;

  estado_t    estado_q, estado_d;
  logic       feita_q, feita_d;
  logic       mult_q, mult_d;
  logic [3:0] codigo_q, codigo_d;

  always_comb begin
    estado_d = estado_q;
    feita_d  = 1'b0;
    codigo_d = codigo_q;
    case (estado_q)
      OCIOSO: begin
        if (estaveis != 4'd0) begin
          if (um_so(estaveis)) begin
            feita_d  = 1'b1;
            codigo_d = estaveis;
            estado_d = PRESSIONADO;
          end else begin
            estado_d = MULTIPLO;
          end
        end
      end
      PRESSIONADO: begin
        if (estaveis == 4'd0) estado_d = OCIOSO;
      end
      MULTIPLO: begin
        if (estaveis == 4'd0) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Registered so it drops on the same edge the FSM leaves MULTIPLO.
    mult_d = (estado_d == MULTIPLO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      feita_q  <= 1'b0;
      mult_q   <= 1'b0;
      codigo_q <= 4'd0;
    end else begin
      estado_q <= estado_d;
      feita_q  <= feita_d;
      mult_q   <= mult_d;
      codigo_q <= codigo_d;
    end
  end

  assign jogada_feita  = feita_q;
  assign multiplo      = mult_q;
  assign jogada_codigo = codigo_q;
  assign db_estado     = {2'b00, estado_q};

endmodule
